// File: rtl/rvc_pkg.sv
// Shared constants, state encoding and small helpers for the RV32 -> RVC compressor.
package rvc_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_WORD    = 3'b010;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [1:0] CQ0 = 2'b00;
    localparam logic [1:0] CQ1 = 2'b01;
    localparam logic [1:0] CQ2 = 2'b10;

    localparam logic [2:0] CF3_ADDI  = 3'b000;
    localparam logic [2:0] CF3_LI    = 3'b010;
    localparam logic [2:0] CF3_SLLI  = 3'b000;
    localparam logic [2:0] CF3_LW    = 3'b010;
    localparam logic [2:0] CF3_SW    = 3'b110;
    localparam logic [2:0] CF3_ARITH = 3'b100;
    localparam logic [3:0] CF4_MV    = 4'b1000;
    localparam logic [3:0] CF4_ADD   = 4'b1001;

    localparam logic [15:0] RVC_NOP      = 16'h0001;
    localparam logic [15:0] RVC_EBREAK   = 16'h9002;
    localparam logic [31:0] INSTR_EBREAK = 32'h00100073;

    typedef enum logic [1:0] {
        EMPTY,
        HALF,
        DRAIN
    } state_t;

    // Registers reachable by the 3-bit compressed register fields.
    function automatic logic is_creg(input logic [4:0] r);
        return r[4:3] == 2'b01;
    endfunction

    // Word-aligned, non-negative offset small enough for C.LW/C.SW.
    function automatic logic mem_off_ok(input logic signed [11:0] off);
        return (off[11:7] == 5'd0) && (off[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/rvc_instr_compressor_if.sv
// Instruction-in / packed-word-out stream bundle for the RVC compressor, plus its statistics.
interface rvc_instr_compressor_if #(
    parameter int unsigned STAT_W = 32
);
    logic              in_valid_i;
    logic              in_ready_o;
    logic [31:0]       in_instr_i;
    logic              in_last_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [31:0]       out_data_o;
    logic              out_last_o;
    logic [STAT_W-1:0] stat_in_cnt_o;
    logic [STAT_W-1:0] stat_c_cnt_o;

    modport master (
        output in_valid_i, in_instr_i, in_last_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, out_last_o, stat_in_cnt_o, stat_c_cnt_o
    );

    modport slave (
        input  in_valid_i, in_instr_i, in_last_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, out_last_o, stat_in_cnt_o, stat_c_cnt_o
    );
endinterface

// File: rtl/rvc_compress_lut.sv
// Combinational RV32I -> RVC encoder: flags whether an instruction has a 16-bit form and builds it.
module rvc_compress_lut
    import rvc_pkg::*;
(
    input  logic [31:0] instr,
    output logic        can_c,
    output logic [15:0] c_instr
);

    logic [6:0]         opcode;
    logic [4:0]         rd;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic signed [11:0] imm_i;
    logic signed [11:0] imm_s;
    logic               imm_i_small;

    assign opcode      = instr[6:0];
    assign rd          = instr[11:7];
    assign funct3      = instr[14:12];
    assign rs1         = instr[19:15];
    assign rs2         = instr[24:20];
    assign funct7      = instr[31:25];
    assign imm_i       = $signed(instr[31:20]);
    assign imm_s       = $signed({instr[31:25], instr[11:7]});
    assign imm_i_small = (imm_i >= -12'sd32) && (imm_i <= 12'sd31);

    always_comb begin
        logic       arith_hit;
        logic [1:0] arith_f2;
        can_c     = 1'b0;
        c_instr   = 16'h0000;
        arith_hit = 1'b0;
        arith_f2  = 2'b00;
        case (opcode)
            OPC_OP_IMM: begin
                if (funct3 == F3_ADD_SUB) begin
                    if (rd == 5'd0 && rs1 == 5'd0 && imm_i == 12'sd0) begin
                        can_c   = 1'b1;
                        c_instr = RVC_NOP;
                    end else if (rd == rs1 && rd != 5'd0 && imm_i != 12'sd0 && imm_i_small) begin
                        can_c   = 1'b1;
                        c_instr = {CF3_ADDI, imm_i[5], rd, imm_i[4:0], CQ1};
                    end else if (rd != 5'd0 && rs1 == 5'd0 && imm_i_small) begin
                        can_c   = 1'b1;
                        c_instr = {CF3_LI, imm_i[5], rd, imm_i[4:0], CQ1};
                    end else if (rd != 5'd0 && rs1 != 5'd0 && imm_i == 12'sd0) begin
                        can_c   = 1'b1;
                        c_instr = {CF4_MV, rd, rs1, CQ2};
                    end
                end else if (funct3 == F3_SLL && funct7 == F7_BASE && rd == rs1 &&
                             rd != 5'd0 && rs2 != 5'd0) begin
                    // RV32 shamt is rs2's field; shamt[5] is always zero here.
                    can_c   = 1'b1;
                    c_instr = {CF3_SLLI, 1'b0, rd, rs2, CQ2};
                end
            end
            OPC_OP: begin
                if (funct7 == F7_BASE && funct3 == F3_ADD_SUB && rd == rs1 &&
                    rd != 5'd0 && rs2 != 5'd0) begin
                    can_c   = 1'b1;
                    c_instr = {CF4_ADD, rd, rs2, CQ2};
                end else if (rd == rs1 && is_creg(rd) && is_creg(rs2)) begin
                    if (funct7 == F7_ALT && funct3 == F3_ADD_SUB) begin
                        arith_hit = 1'b1;
                        arith_f2  = 2'b00;
                    end else if (funct7 == F7_BASE && funct3 == F3_XOR) begin
                        arith_hit = 1'b1;
                        arith_f2  = 2'b01;
                    end else if (funct7 == F7_BASE && funct3 == F3_OR) begin
                        arith_hit = 1'b1;
                        arith_f2  = 2'b10;
                    end else if (funct7 == F7_BASE && funct3 == F3_AND) begin
                        arith_hit = 1'b1;
                        arith_f2  = 2'b11;
                    end
                    if (arith_hit) begin
                        can_c   = 1'b1;
                        c_instr = {CF3_ARITH, 1'b0, 2'b11, rd[2:0], arith_f2, rs2[2:0], CQ1};
                    end
                end
            end
            OPC_LOAD: begin
                if (funct3 == F3_WORD && is_creg(rs1) && is_creg(rd) && mem_off_ok(imm_i)) begin
                    can_c   = 1'b1;
                    c_instr = {CF3_LW, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], CQ0};
                end
            end
            OPC_STORE: begin
                if (funct3 == F3_WORD && is_creg(rs1) && is_creg(rs2) && mem_off_ok(imm_s)) begin
                    can_c   = 1'b1;
                    c_instr = {CF3_SW, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6], rs2[2:0], CQ0};
                end
            end
            OPC_SYSTEM: begin
                if (instr == INSTR_EBREAK) begin
                    can_c   = 1'b1;
                    c_instr = RVC_EBREAK;
                end
            end
            default: begin
                can_c   = 1'b0;
                c_instr = 16'h0000;
            end
        endcase
    end

endmodule

// File: rtl/rvc_instr_compressor.sv
// Streaming RV32 -> RVC compressor packing 16/32-bit parcels little-endian into 32-bit words.
// Define RVC_COMPRESS_STATS_EN to build the accepted/compressed instruction counters.
module rvc_instr_compressor
    import rvc_pkg::*;
#(
    parameter int unsigned STAT_W   = 32,
    parameter logic [15:0] PAD_HALF = RVC_NOP
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    rvc_instr_compressor_if.slave io
);

    state_t      state;
    logic [15:0] res_p1;
    logic        vld_p1;
    logic [31:0] data_p1;
    logic        last_p1;
    logic        out_free;
    logic        accept_p0;
    logic        can_c;
    logic [15:0] c_instr;

    rvc_compress_lut u_lut (
        .instr   (io.in_instr_i),
        .can_c   (can_c),
        .c_instr (c_instr)
    );

    assign out_free      = !vld_p1 || io.out_ready_i;
    assign io.in_ready_o = (state != DRAIN) && out_free;
    assign accept_p0     = io.in_valid_i && io.in_ready_o;

    assign io.out_valid_o = vld_p1;
    assign io.out_data_o  = data_p1;
    assign io.out_last_o  = last_p1;

    // Stage p0 -> p1: residue/FSM update and one-entry output register load.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= EMPTY;
            res_p1  <= 16'h0000;
            vld_p1  <= 1'b0;
            data_p1 <= 32'h0000_0000;
            last_p1 <= 1'b0;
        end else begin
            if (vld_p1 && io.out_ready_i) begin
                vld_p1 <= 1'b0;
            end
            case (state)
                EMPTY: begin
                    if (accept_p0) begin
                        if (can_c && io.in_last_i) begin
                            vld_p1  <= 1'b1;
                            data_p1 <= {PAD_HALF, c_instr};
                            last_p1 <= 1'b1;
                        end else if (can_c) begin
                            res_p1 <= c_instr;
                            state  <= HALF;
                        end else begin
                            vld_p1  <= 1'b1;
                            data_p1 <= io.in_instr_i;
                            last_p1 <= io.in_last_i;
                        end
                    end
                end
                HALF: begin
                    if (accept_p0) begin
                        vld_p1 <= 1'b1;
                        if (can_c) begin
                            data_p1 <= {c_instr, res_p1};
                            last_p1 <= io.in_last_i;
                            state   <= EMPTY;
                        end else begin
                            // Wide instruction straddles the word boundary; its upper half carries over.
                            data_p1 <= {io.in_instr_i[15:0], res_p1};
                            last_p1 <= 1'b0;
                            res_p1  <= io.in_instr_i[31:16];
                            state   <= io.in_last_i ? DRAIN : HALF;
                        end
                    end
                end
                DRAIN: begin
                    if (out_free) begin
                        vld_p1  <= 1'b1;
                        data_p1 <= {PAD_HALF, res_p1};
                        last_p1 <= 1'b1;
                        state   <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

`ifdef RVC_COMPRESS_STATS_EN
    logic [STAT_W-1:0] in_cnt;
    logic [STAT_W-1:0] c_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            in_cnt <= '0;
            c_cnt  <= '0;
        end else if (accept_p0) begin
            in_cnt <= in_cnt + STAT_W'(1);
            if (can_c) begin
                c_cnt <= c_cnt + STAT_W'(1);
            end
        end
    end

    assign io.stat_in_cnt_o = in_cnt;
    assign io.stat_c_cnt_o  = c_cnt;
`else
    assign io.stat_in_cnt_o = {STAT_W{1'b0}};
    assign io.stat_c_cnt_o  = {STAT_W{1'b0}};
`endif

endmodule

// File: tb/tb_rvc_instr_compressor.sv
// Directed-vector bench for rvc_instr_compressor: packing, draining, back-pressure, reset and encodings.
module tb_rvc_instr_compressor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rvc_instr_compressor_if #(.STAT_W(32)) io ();

    rvc_instr_compressor #(.STAT_W(32), .PAD_HALF(16'h0001)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .io    (io)
    );

    int total = 0;
    int bad = 0;
    int timeouts = 0;
    int exp_in = 0;
    int exp_c = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] word;
        logic        is_c;
    } vec_t;

    // Presents one instruction and holds it until accepted (bounded).
    task automatic send(input logic [31:0] instr, input logic last, input logic is_c);
        int n;
        n = 0;
        io.in_valid_i = 1'b1;
        io.in_instr_i = instr;
        io.in_last_i  = last;
        while (io.in_ready_o !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) begin
            timeouts++;
        end else begin
            exp_in++;
            if (is_c) exp_c++;
        end
        @(posedge clk);
        #1;
        io.in_valid_i = 1'b0;
        io.in_last_i  = 1'b0;
    endtask

    // Waits (bounded) for a packed word, captures it and lets it be consumed.
    task automatic wait_out(output logic [31:0] d, output logic l);
        int n;
        n = 0;
        while (io.out_valid_o !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 20) begin
            timeouts++;
            d = 32'hxxxx_xxxx;
            l = 1'bx;
        end else begin
            d = io.out_data_o;
            l = io.out_last_o;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        io.in_valid_i  = 1'b0;
        io.in_instr_i  = 32'h0;
        io.in_last_i   = 1'b0;
        io.out_ready_i = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (io.out_valid_o !== 1'b0 || io.out_data_o !== 32'h0 || io.out_last_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_out got valid=%b data=%h last=%b want 0 0 0",
                     io.out_valid_o, io.out_data_o, io.out_last_o);
        end
        total++;
        if (io.in_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready got %b want 1", io.in_ready_o);
        end
        total++;
        if (io.stat_in_cnt_o !== 32'h0 || io.stat_c_cnt_o !== 32'h0) begin
            bad++;
            $display("FAIL reset_stats got in=%0d c=%0d want 0 0", io.stat_in_cnt_o, io.stat_c_cnt_o);
        end
        rst = 1'b0;
        exp_in = 0;
        exp_c  = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_addi_pair();
        logic [31:0] d;
        logic        l;
        send(32'h00140413, 1'b0, 1'b1);
        total++;
        if (io.out_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL pair_residue_held got out_valid=%b want 0", io.out_valid_o);
        end
        send(32'h00140413, 1'b1, 1'b1);
        wait_out(d, l);
        total++;
        if (d !== 32'h04050405 || l !== 1'b1) begin
            bad++;
            $display("FAIL pair_word got %h last=%b want 04050405 last=1", d, l);
        end
        total++;
        if (io.out_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL pair_single_word got out_valid=%b want 0", io.out_valid_o);
        end
    endtask

    task automatic test_add_single();
        logic [31:0] d;
        logic        l;
        send(32'h00B50533, 1'b1, 1'b1);
        wait_out(d, l);
        total++;
        if (d !== 32'h0001952E || l !== 1'b1) begin
            bad++;
            $display("FAIL add_single got %h last=%b want 0001952e last=1", d, l);
        end
    endtask

    task automatic test_half_wide_drain();
        logic [31:0] d;
        logic        l;
        send(32'h00140413, 1'b0, 1'b1);
        send(32'h008000EF, 1'b1, 1'b0);
        total++;
        if (io.in_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL drain_in_ready got %b want 0", io.in_ready_o);
        end
        wait_out(d, l);
        total++;
        if (d !== 32'h00EF0405 || l !== 1'b0) begin
            bad++;
            $display("FAIL drain_first got %h last=%b want 00ef0405 last=0", d, l);
        end
        wait_out(d, l);
        total++;
        if (d !== 32'h00010080 || l !== 1'b1) begin
            bad++;
            $display("FAIL drain_pad got %h last=%b want 00010080 last=1", d, l);
        end
        total++;
        if (io.in_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL drain_done_ready got %b want 1", io.in_ready_o);
        end
    endtask

    task automatic test_nop_passthrough();
        logic [31:0] d;
        logic        l;
        send(32'h00000013, 1'b0, 1'b1);
        send(32'h00000013, 1'b1, 1'b1);
        wait_out(d, l);
        total++;
        if (d !== 32'h00010001 || l !== 1'b1) begin
            bad++;
            $display("FAIL nop_pair got %h last=%b want 00010001 last=1", d, l);
        end
        send(32'h00000000, 1'b1, 1'b0);
        wait_out(d, l);
        total++;
        if (d !== 32'h00000000 || l !== 1'b1) begin
            bad++;
            $display("FAIL zero_passthrough got %h last=%b want 00000000 last=1", d, l);
        end
    endtask

    task automatic test_rules();
        vec_t        v [13];
        logic [31:0] d;
        logic        l;
        v = '{
            '{32'h00500513, 32'h00014515, 1'b1},   // c.li a0,5
            '{32'h00058513, 32'h0001852E, 1'b1},   // c.mv a0,a1
            '{32'hFE040413, 32'h00011401, 1'b1},   // c.addi s0,-32
            '{32'h02040413, 32'h02040413, 1'b0},   // addi s0,s0,32 out of range
            '{32'h00351513, 32'h0001050E, 1'b1},   // c.slli a0,3
            '{32'h40940433, 32'h00018C05, 1'b1},   // c.sub s0,s1
            '{32'h00947433, 32'h00018C65, 1'b1},   // c.and s0,s1
            '{32'h40948433, 32'h40948433, 1'b0},   // sub s0,s1,s1 rd!=rs1
            '{32'h00442503, 32'h00014048, 1'b1},   // c.lw a0,4(s0)
            '{32'h08042503, 32'h08042503, 1'b0},   // lw a0,128(s0) offset too big
            '{32'h06B4AE23, 32'h0001DCEC, 1'b1},   // c.sw a1,124(s1)
            '{32'h00100073, 32'h00019002, 1'b1},   // c.ebreak
            '{32'h000080E7, 32'h000080E7, 1'b0}    // jalr never compressed
        };
        for (int i = 0; i < 13; i++) begin
            send(v[i].instr, 1'b1, v[i].is_c);
            wait_out(d, l);
            total++;
            if (d !== v[i].word || l !== 1'b1) begin
                bad++;
                $display("FAIL rule_%0d instr=%h got %h last=%b want %h last=1",
                         i, v[i].instr, d, l, v[i].word);
            end
        end
    endtask

    task automatic test_backpressure();
        io.out_ready_i = 1'b0;
        send(32'h00B50533, 1'b1, 1'b1);
        io.in_valid_i = 1'b1;
        io.in_instr_i = 32'h008000EF;
        io.in_last_i  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (io.out_valid_o !== 1'b1 || io.out_data_o !== 32'h0001952E ||
                io.out_last_o !== 1'b1 || io.in_ready_o !== 1'b0) begin
                bad++;
                $display("FAIL stall_%0d got valid=%b data=%h last=%b in_ready=%b want 1 0001952e 1 0",
                         i, io.out_valid_o, io.out_data_o, io.out_last_o, io.in_ready_o);
            end
        end
        io.out_ready_i = 1'b1;
        #1;
        total++;
        if (io.in_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL stall_release_ready got %b want 1", io.in_ready_o);
        end
        @(posedge clk);
        #1;
        exp_in++;
        io.in_valid_i = 1'b0;
        io.in_last_i  = 1'b0;
        total++;
        if (io.out_valid_o !== 1'b1 || io.out_data_o !== 32'h008000EF || io.out_last_o !== 1'b1) begin
            bad++;
            $display("FAIL stall_next_word got valid=%b data=%h last=%b want 1 008000ef 1",
                     io.out_valid_o, io.out_data_o, io.out_last_o);
        end
        @(posedge clk);
        #1;
        total++;
        if (io.out_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL stall_no_dup got out_valid=%b want 0", io.out_valid_o);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic        l;
        send(32'h00140413, 1'b0, 1'b1);
        rst = 1'b1;
        #2;
        total++;
        if (io.out_valid_o !== 1'b0 || io.in_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL midreset_async got out_valid=%b in_ready=%b want 0 1",
                     io.out_valid_o, io.in_ready_o);
        end
        exp_in = 0;
        exp_c  = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(32'h00B50533, 1'b1, 1'b1);
        wait_out(d, l);
        total++;
        if (d !== 32'h0001952E || l !== 1'b1) begin
            bad++;
            $display("FAIL midreset_residue_gone got %h last=%b want 0001952e last=1", d, l);
        end
    endtask

    task automatic test_stats();
        logic [31:0] want_in;
        logic [31:0] want_c;
`ifdef RVC_COMPRESS_STATS_EN
        want_in = 32'(exp_in);
        want_c  = 32'(exp_c);
`else
        want_in = 32'h0;
        want_c  = 32'h0;
`endif
        total++;
        if (io.stat_in_cnt_o !== want_in || io.stat_c_cnt_o !== want_c) begin
            bad++;
            $display("FAIL stats got in=%0d c=%0d want in=%0d c=%0d",
                     io.stat_in_cnt_o, io.stat_c_cnt_o, want_in, want_c);
        end
    endtask

    task automatic test_no_timeouts();
        total++;
        if (timeouts !== 0) begin
            bad++;
            $display("FAIL handshake_timeouts got %0d want 0", timeouts);
        end
    endtask

    initial begin
        test_reset();
        test_addi_pair();
        test_add_single();
        test_stats();
        test_half_wide_drain();
        test_nop_passthrough();
        test_rules();
        test_stats();
        test_backpressure();
        test_reset_mid();
        test_stats();
        test_no_timeouts();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
